mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register and write-back controller directly downstream of the memory-access stage.
- Captures the 38-bit memory-access output bus and the memory read data. Selects the write-back value and drives the register-file write port.
- Flags writes to R7 (the PC) as a redirect to fetch. Exposes a forwarding tap for the hazard unit and keeps a retired-instruction counter.

Parameters:
- DATA_W, 16, datapath and register width
- BUS_W, 38, width of the memory-access output bus
- PC_REG, 3'd7, register index treated as the PC
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- stall  in  1  hold the stage contents; take no new input
- flush  in  1  replace the captured instruction with a bubble
- mem_bus  in  BUS_W  memory-access output. [0]=mem_read, [1]=reg_wr, [4:2]=rd, [5]=valid, [21:6]=result, [37:22]=aux
- mem_rdata  in  DATA_W  memory read data for the instruction on mem_bus
- rf_we  out  1  register-file write enable
- rf_waddr  out  3  register-file write index
- rf_wdata  out  DATA_W  register-file write data
- pc_redirect  out  1  one-cycle pulse: a retiring instruction wrote PC_REG
- pc_target  out  DATA_W  redirect target, equal to rf_wdata while pc_redirect=1
- fwd_valid  out  1  fwd_reg/fwd_data hold a pending write
- fwd_reg  out  3  forwarding destination index
- fwd_data  out  DATA_W  forwarding value
- retired  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset: resetn is asynchronous and active-low. While it is low, every output and every internal register is 0, including retired and the stage valid bit.
- Capture at the rising clk edge:
  - flush=1: load a bubble (valid=0, reg_wr=0). Flush overrides stall.
  - else stall=1: hold all state. The write port does not re-fire; rf_we is held 0 during stall cycles.
  - else: capture mem_bus. The data word is mem_rdata if mem_bus[0]=1, else mem_bus[21:6]. This mux is applied at capture, because mem_rdata is only valid in the same cycle as mem_bus.
- Latency: 1 cycle. An instruction presented in cycle N writes the register file in cycle N+1.
- rf_we = stage_valid & reg_wr & ~stall_d.
  - stall_d is the stall value registered on the same edge.
  - rf_we is asserted exactly once per captured instruction, including across multi-cycle stalls.
- rf_waddr = captured rd; rf_wdata = captured data word. Both are stable whenever rf_we=1.
- pc_redirect = rf_we & (rf_waddr==PC_REG). It is a single-cycle pulse; pc_target = rf_wdata.
- Forwarding tap:
  - fwd_valid = stage_valid & reg_wr. It stays high through stalls.
  - fwd_reg and fwd_data mirror the captured rd and data word.
- retired counter:
  - Increments by 1 in the cycle rf_we would be evaluated for a valid instruction, whether or not reg_wr is set.
  - Stores and branches without write-back also count; bubbles do not.
  - Wraps modulo 2^CNT_W without saturation.
- A valid instruction with reg_wr=0 does not write the register file, does not redirect, and is counted.
- Reset asserted mid-stall discards the held instruction. Its write never occurs.
- Flush in the same cycle as a pending write-back: the instruction already in the stage still writes this cycle. Only the incoming instruction is dropped.
- bus[37:22] (aux) is ignored by this stage.

Decomposition:
- Shared package riscpkg:
  - bus field offsets: MEMRD_BIT=0, REGWR_BIT=1, RD_LSB=2, VALID_BIT=5, RES_LSB=6, AUX_LSB=22
  - BUS_W, DATA_W, PC_REG
  - the opcode-independent bubble constant (all zero)
- The same offsets are used by memory_access and the execute stage.
- One sub-module, wb_retire_counter: counter with enable, wrap, and async active-low reset. Everything else stays flat in mem_wb_stage.

Test Plan:
1. ALU write-back: bus {valid=1, reg_wr=1, rd=3, mem_read=0, result=16'h1234}, no stall -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234, retired=1, pc_redirect=0.
2. Load: bus {valid=1, reg_wr=1, rd=5, mem_read=1, result=16'hAAAA}, mem_rdata=16'h00C3 -> rf_wdata=16'h00C3, not 16'hAAAA.
3. Stall hold: capture rd=2/16'h0042, then stall=1 for 3 cycles:
   - rf_we pulses only once;
   - fwd_valid=1, fwd_reg=2, fwd_data=16'h0042 throughout;
   - retired increments once.
4. PC write: rd=7, result=16'h0100, reg_wr=1 -> one-cycle pc_redirect=1, pc_target=16'h0100. The following bubble gives pc_redirect=0.
5. Flush vs stall: flush=1 and stall=1 with a valid bus input -> next cycle fwd_valid=0, rf_we=0, retired unchanged. The previous instruction's write still completed.
6. Reset and wrap:
   - preload retired to 16'hFFFF (force), retire one instruction -> retired=16'h0000;
   - drop resetn asynchronously mid-cycle -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/riscpkg.sv
// Shared pipeline definitions: memory-access bus field
// offsets, datapath widths and the bubble constant.
package riscpkg;

   localparam int DATA_W = 16;
   localparam int BUS_W  = 38;
   localparam logic [2:0] PC_REG = 3'd7;

   localparam int MEMRD_BIT = 0;
   localparam int REGWR_BIT = 1;
   localparam int RD_LSB    = 2;
   localparam int VALID_BIT = 5;
   localparam int RES_LSB   = 6;
   localparam int AUX_LSB   = 22;

   localparam logic [BUS_W-1:0] BUBBLE = '0;

   // Write-back word: load data or ALU result.
   function automatic logic [DATA_W-1:0] wb_word(
      input logic [BUS_W-1:0]  bus,
      input logic [DATA_W-1:0] rdata
   );
      if (bus[MEMRD_BIT])
         return rdata;
      return bus[RES_LSB +: DATA_W];
   endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Retired-instruction counter: +1 when en, wraps modulo 2^W.
// Ports: clk, resetn (async low), en, count.
module wb_retire_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count <= '0;
      else if (en)
         count <= count + {{(W-1){1'b0}}, 1'b1};
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back controller.
// Ports: clk, resetn, stall, flush, mem_bus, mem_rdata in;
// rf write port, pc redirect, forwarding tap, retired out.
module mem_wb_stage
   import riscpkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stall,
   input  logic              flush,
   input  logic [BUS_W-1:0]  mem_bus,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rf_we,
   output logic [2:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              pc_redirect,
   output logic [DATA_W-1:0] pc_target,
   output logic              fwd_valid,
   output logic [2:0]        fwd_reg,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retired
);

   logic              vld_q;
   logic              wr_q;
   logic [2:0]        rd_q;
   logic [DATA_W-1:0] data_q;
   logic              stall_d;
   logic              take;
   logic              unused_aux;

   assign unused_aux = ^mem_bus[BUS_W-1:AUX_LSB];

   // Load mux sits at capture: mem_rdata is only
   // valid alongside its instruction on mem_bus.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_q   <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         stall_d <= 1'b0;
      end else begin
         stall_d <= stall & ~flush;
         if (flush) begin
            vld_q  <= BUBBLE[VALID_BIT];
            wr_q   <= BUBBLE[REGWR_BIT];
            rd_q   <= BUBBLE[RD_LSB +: 3];
            data_q <= BUBBLE[RES_LSB +: DATA_W];
         end else if (!stall) begin
            vld_q  <= mem_bus[VALID_BIT];
            wr_q   <= mem_bus[REGWR_BIT];
            rd_q   <= mem_bus[RD_LSB +: 3];
            data_q <= wb_word(mem_bus, mem_rdata);
         end
      end
   end

   // stall_d masks re-firing while the stage holds.
   assign rf_we       = vld_q & wr_q & ~stall_d;
   assign rf_waddr    = rd_q;
   assign rf_wdata    = data_q;
   assign pc_redirect = rf_we & (rd_q == PC_REG);
   assign pc_target   = data_q;

   assign fwd_valid = vld_q & wr_q;
   assign fwd_reg   = rd_q;
   assign fwd_data  = data_q;

   // Counted when captured, so the count is visible
   // in the same cycle as the write-back.
   assign take = ~flush & ~stall & mem_bus[VALID_BIT];

   wb_retire_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .en     (take),
      .count  (retired)
   );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Each task drives one scenario and checks inline.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stall;
   logic        flush;
   logic [37:0] mem_bus;
   logic [15:0] mem_rdata;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        pc_redirect;
   logic [15:0] pc_target;
   logic        fwd_valid;
   logic [2:0]  fwd_reg;
   logic [15:0] fwd_data;
   logic [15:0] retired;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk         (clk),
      .resetn      (resetn),
      .stall       (stall),
      .flush       (flush),
      .mem_bus     (mem_bus),
      .mem_rdata   (mem_rdata),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .pc_redirect (pc_redirect),
      .pc_target   (pc_target),
      .fwd_valid   (fwd_valid),
      .fwd_reg     (fwd_reg),
      .fwd_data    (fwd_data),
      .retired     (retired)
   );

   function automatic logic [37:0] mk(
      input logic v, input logic w, input logic [2:0] rd,
      input logic m, input logic [15:0] res
   );
      return {16'hDEAD, res, v, rd, w, m};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_bus = mk(1, 1, 3'd4, 0, 16'h5555);
      mem_rdata = 16'h0;
      step(); step();
      tests++;
      if ({rf_we, fwd_valid, pc_redirect} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags: got %b exp 000",
                  {rf_we, fwd_valid, pc_redirect});
      end
      tests++;
      if ({retired, rf_wdata, rf_waddr} !== 35'd0) begin
         fails++;
         $display("FAIL reset_regs: got ret=%h wd=%h wa=%0d exp 0",
                  retired, rf_wdata, rf_waddr);
      end
      mem_bus = mk(0, 0, 0, 0, 0);
      resetn = 1'b1;
      step();
   endtask

   task automatic test_alu_wb();
      mem_bus = mk(1, 1, 3'd3, 0, 16'h1234);
      step();
      mem_bus = mk(0, 0, 0, 0, 0);
      tests++;
      if ({rf_we, rf_waddr, rf_wdata, pc_redirect}
          !== {1'b1, 3'd3, 16'h1234, 1'b0}) begin
         fails++;
         $display("FAIL alu_wb: got we=%b wa=%0d wd=%h pr=%b exp 1 3 1234 0",
                  rf_we, rf_waddr, rf_wdata, pc_redirect);
      end
      tests++;
      if (retired !== 16'd1) begin
         fails++;
         $display("FAIL alu_retired: got %0d exp 1", retired);
      end
   endtask

   task automatic test_load();
      mem_bus = mk(1, 1, 3'd5, 1, 16'hAAAA);
      mem_rdata = 16'h00C3;
      step();
      mem_bus = mk(0, 0, 0, 0, 0);
      mem_rdata = 16'hFFFF;
      tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 16'h00C3}) begin
         fails++;
         $display("FAIL load_wb: got we=%b wa=%0d wd=%h exp 1 5 00c3",
                  rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_stall_hold();
      int pulses;
      mem_bus = mk(1, 1, 3'd2, 0, 16'h0042);
      step();
      pulses = int'(rf_we);
      tests++;
      if (retired !== 16'd3) begin
         fails++;
         $display("FAIL stall_ret0: got %0d exp 3", retired);
      end
      stall = 1'b1;
      mem_bus = mk(1, 1, 3'd6, 0, 16'h7777);
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(rf_we);
         tests++;
         if ({fwd_valid, fwd_reg, fwd_data}
             !== {1'b1, 3'd2, 16'h0042}) begin
            fails++;
            $display("FAIL stall_fwd%0d: got v=%b r=%0d d=%h exp 1 2 0042",
                     i, fwd_valid, fwd_reg, fwd_data);
         end
         tests++;
         if (retired !== 16'd3) begin
            fails++;
            $display("FAIL stall_ret%0d: got %0d exp 3", i + 1, retired);
         end
      end
      tests++;
      if (pulses !== 1) begin
         fails++;
         $display("FAIL stall_pulses: got %0d exp 1", pulses);
      end
      stall = 1'b0;
      mem_bus = mk(0, 0, 0, 0, 0);
      step();
      tests++;
      if ({rf_we, fwd_valid} !== 2'b00 || retired !== 16'd3) begin
         fails++;
         $display("FAIL stall_after: got we=%b fv=%b ret=%0d exp 0 0 3",
                  rf_we, fwd_valid, retired);
      end
   endtask

   task automatic test_pc_write();
      mem_bus = mk(1, 1, 3'd7, 0, 16'h0100);
      step();
      mem_bus = mk(0, 0, 0, 0, 0);
      tests++;
      if ({pc_redirect, pc_target} !== {1'b1, 16'h0100}) begin
         fails++;
         $display("FAIL pc_redirect: got pr=%b pt=%h exp 1 0100",
                  pc_redirect, pc_target);
      end
      step();
      tests++;
      if (pc_redirect !== 1'b0) begin
         fails++;
         $display("FAIL pc_bubble: got %b exp 0", pc_redirect);
      end
      mem_bus = mk(1, 0, 3'd7, 0, 16'h0200);
      step();
      mem_bus = mk(0, 0, 0, 0, 0);
      tests++;
      if ({rf_we, pc_redirect} !== 2'b00 || retired !== 16'd5) begin
         fails++;
         $display("FAIL no_wr: got we=%b pr=%b ret=%0d exp 0 0 5",
                  rf_we, pc_redirect, retired);
      end
   endtask

   task automatic test_flush_stall();
      mem_bus = mk(1, 1, 3'd1, 0, 16'h0011);
      step();
      flush = 1'b1;
      stall = 1'b1;
      mem_bus = mk(1, 1, 3'd4, 0, 16'h0044);
      tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd1, 16'h0011}) begin
         fails++;
         $display("FAIL flush_prev: got we=%b wa=%0d wd=%h exp 1 1 0011",
                  rf_we, rf_waddr, rf_wdata);
      end
      step();
      flush = 1'b0;
      stall = 1'b0;
      mem_bus = mk(0, 0, 0, 0, 0);
      tests++;
      if ({fwd_valid, rf_we} !== 2'b00 || retired !== 16'd6) begin
         fails++;
         $display("FAIL flush_drop: got fv=%b we=%b ret=%0d exp 0 0 6",
                  fwd_valid, rf_we, retired);
      end
   endtask

   task automatic test_wrap_async_reset();
      mem_bus = mk(1, 1, 3'd1, 0, 16'hBEEF);
      force dut.u_cnt.count = 16'hFFFF;
      #1;
      release dut.u_cnt.count;
      step();
      tests++;
      if (retired !== 16'h0000) begin
         fails++;
         $display("FAIL wrap: got %h exp 0000", retired);
      end
      stall = 1'b1;
      step();
      #2;
      resetn = 1'b0;
      #1;
      tests++;
      if ({rf_we, fwd_valid, pc_redirect, rf_waddr,
           rf_wdata, fwd_data, retired} !== 54'd0) begin
         fails++;
         $display("FAIL async_rst: got we=%b fv=%b wd=%h ret=%h exp 0",
                  rf_we, fwd_valid, rf_wdata, retired);
      end
      @(negedge clk);
      resetn = 1'b1;
      step();
      tests++;
      if ({rf_we, fwd_valid} !== 2'b00) begin
         fails++;
         $display("FAIL rst_discard: got we=%b fv=%b exp 0 0",
                  rf_we, fwd_valid);
      end
      stall = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_alu_wb();
      test_load();
      test_stall_hold();
      test_pc_write();
      test_flush_stall();
      test_wrap_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
